// File: rtl/omp_q_pkg.sv
// Shared definitions for the omp_q memory burst controller.
// Holds the default widths and sizes, the FSM state encoding and the
// burst direction constants. Every omp_q_* module imports this package.
package omp_q_pkg;

    localparam int DEF_DWIDTH   = 32;
    localparam int DEF_AWIDTH   = 11;
    localparam int DEF_MEM_SIZE = 2048;  // always 2**DEF_AWIDTH

    // Values carried on the 'mode' input.
    localparam logic MODE_WR = 1'b0;
    localparam logic MODE_RD = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/omp_q_rd_buf.sv
// Two-entry read-data buffer for the omp_q controller.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (flushes the buffer)
//   push, din  - write one word into the tail
//   pop        - drop the head word (caller only pops when occ != 0)
//   dout       - head word
//   occ        - number of stored words, 0..2
// push and pop may both be asserted in the same cycle.
module omp_q_rd_buf
    import omp_q_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout,
    output logic [1:0]        occ
);

    logic [DWIDTH-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/omp_q_mem_ctrl.sv
// Burst controller between two streams and a single-port RAM.
// A command (start/mode/base/len) is accepted in IDLE. A write burst moves
// len words from the s_* stream into the RAM; a read burst moves len words
// from the RAM onto the m_* stream through a 2-entry buffer. Addresses wrap
// modulo MEM_SIZE. 'done' pulses once, one cycle after the DONE state.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   start, mode, base, len   - command (mode 0 = write, 1 = read)
//   busy, done               - burst in progress / completion pulse
//   s_data, s_valid, s_ready - write-data stream in
//   m_data, m_valid, m_ready - read-data stream out
//   addr0, ce0, we0, d0, q0  - RAM port (q0 valid one cycle after a read)
//   fsm_state                - current FSM state, for observation
// Stream handshake: a word transfers in a cycle where valid and ready are
// both high; valid never depends on ready, and the offered word is held
// stable while valid is high and ready is low.
module omp_q_mem_ctrl
    import omp_q_pkg::*;
#(
    parameter int DWIDTH   = DEF_DWIDTH,
    parameter int AWIDTH   = DEF_AWIDTH,
    parameter int MEM_SIZE = DEF_MEM_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [AWIDTH-1:0] base,
    input  logic [AWIDTH:0]   len,
    output logic              busy,
    output logic              done,
    input  logic [DWIDTH-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [AWIDTH-1:0] addr0,
    output logic              ce0,
    output logic              we0,
    output logic [DWIDTH-1:0] d0,
    input  logic [DWIDTH-1:0] q0,
    output state_t            fsm_state
);

    localparam logic [AWIDTH:0] MEM_SIZE_W = (AWIDTH+1)'(MEM_SIZE);

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] base_q;
    logic [AWIDTH:0]   len_q;
    logic [AWIDTH:0]   idx_q;      // words written, or reads issued
    logic [AWIDTH:0]   rcnt_q;     // read words handed out on m_*
    logic              rd_pend_q;  // a read was issued last cycle
    logic [1:0]        occ;
    logic [DWIDTH-1:0] head;
    logic [AWIDTH:0]   addr_sum;
    logic [AWIDTH-1:0] cur_addr;
    logic              in_wr, in_rd;
    logic              wr_fire, rd_issue, m_fire;
    logic [2:0]        room_used, room_limit;

    assign in_wr = (state_q == ST_WRITE);
    assign in_rd = (state_q == ST_READ);

    assign addr_sum = {1'b0, base_q} + {1'b0, idx_q[AWIDTH-1:0]};
    assign cur_addr = (addr_sum >= MEM_SIZE_W) ? AWIDTH'(addr_sum - MEM_SIZE_W)
                                                : addr_sum[AWIDTH-1:0];

    assign m_valid = in_rd && (occ != 2'd0);
    assign m_fire  = m_valid && m_ready;
    assign wr_fire = in_wr && s_valid;

    // Buffer slots plus the read in flight must stay within two words.
    // A pop in this cycle frees a slot, which keeps one word per cycle
    // flowing when m_ready is held high.
    assign room_used  = {1'b0, occ} + {2'b00, rd_pend_q};
    assign room_limit = 3'd2 + {2'b00, m_fire};
    assign rd_issue   = in_rd && (idx_q < len_q) && (room_used < room_limit);

    assign ce0     = wr_fire || rd_issue;
    assign we0     = wr_fire;
    assign d0      = wr_fire ? s_data : '0;
    assign addr0   = ce0 ? cur_addr : '0;
    assign s_ready = in_wr;
    assign busy    = in_wr || in_rd;
    assign m_data  = m_valid ? head : '0;
    assign fsm_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0)            state_d = ST_DONE;
                    else if (mode == MODE_RD) state_d = ST_READ;
                    else                      state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (wr_fire && ((idx_q + 1'b1) == len_q)) state_d = ST_DONE;
            end
            ST_READ: begin
                if (m_fire && ((rcnt_q + 1'b1) == len_q)) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            rcnt_q    <= '0;
            rd_pend_q <= 1'b0;
            done      <= 1'b0;
        end else begin
            done      <= (state_q == ST_DONE);
            rd_pend_q <= rd_issue;
            if ((state_q == ST_IDLE) && start) begin
                base_q <= base;
                len_q  <= len;
                idx_q  <= '0;
                rcnt_q <= '0;
            end else begin
                if (wr_fire || rd_issue) idx_q <= idx_q + 1'b1;
                if (m_fire)              rcnt_q <= rcnt_q + 1'b1;
            end
        end
    end

    omp_q_rd_buf #(.DWIDTH(DWIDTH)) u_rd_buf (
        .clk  (clk),
        .rst  (rst),
        .push (rd_pend_q),
        .pop  (m_fire),
        .din  (q0),
        .dout (head),
        .occ  (occ)
    );

endmodule

// File: tb/tb_omp_q_mem_ctrl.sv
module tb_omp_q_mem_ctrl;
    import omp_q_pkg::*;

    localparam int DW = 32;
    localparam int AW = 11;
    localparam int MS = 2048;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          start, mode;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          busy, done;
    logic [DW-1:0] s_data;
    logic          s_valid, s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid, m_ready;
    logic [AW-1:0] addr0;
    logic          ce0, we0;
    logic [DW-1:0] d0, q0;
    state_t        fsm_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    omp_q_mem_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .base(base), .len(len),
        .busy(busy), .done(done),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .addr0(addr0), .ce0(ce0), .we0(we0), .d0(d0), .q0(q0),
        .fsm_state(fsm_state)
    );

    // Behavioural single-port RAM: one-cycle read, write-first q0.
    logic [DW-1:0] ram [MS];
    always @(posedge clk) begin
        if (ce0) begin
            if (we0) begin
                ram[addr0] <= d0;
                q0         <= d0;
            end else begin
                q0 <= ram[addr0];
            end
        end
    end

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_mem [MS];
    logic [DW-1:0] exp_w, held;
    int nchk = 0, nerr = 0;
    int done_cnt = 0, done_cyc = -1, first_mv = -1, last_hs = -1, start_cyc = 0;
    int outst = 0, max_outst = 0;
    int rdy_mode = 0;
    bit ce0_seen = 0, stall_prev = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            outst      = 0;
        end else begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc - start_cyc;
            end
            if (ce0) ce0_seen = 1'b1;
            if (stall_prev) begin
                check("stall_valid", 64'(m_valid), 64'd1);
                check("stall_data", 64'(m_data), 64'(held));
            end
            if (m_valid && first_mv < 0) first_mv = cyc - start_cyc;
            outst = outst + ((ce0 && !we0) ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
            if (outst > max_outst) max_outst = outst;
            if (m_valid && m_ready) begin
                last_hs = cyc - start_cyc;
                if (exp_q.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL extra_word: got %0h with nothing expected (cycle %0d)", m_data, cyc);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("rd_data", 64'(m_data), 64'(exp_w));
                end
            end
            stall_prev = m_valid && !m_ready;
            held       = m_data;
        end
    end

    // m_ready driver: mode 0 always ready; mode 1 repeats 1,0,0,1 then 4 random cycles.
    int pat = 0;
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                m_ready = 1'b1;
            end else begin
                case (pat % 8)
                    0: m_ready = 1'b1;
                    1: m_ready = 1'b0;
                    2: m_ready = 1'b0;
                    3: m_ready = 1'b1;
                    default: m_ready = 1'($urandom_range(0, 1));
                endcase
                pat++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input logic m, input logic [AW-1:0] b, input logic [AW:0] n);
        step();
        start = 1'b1; mode = m; base = b; len = n;
        start_cyc = cyc;
        first_mv  = -1;
        last_hs   = -1;
        max_outst = 0;
        step();
        start = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] b, input int n, input logic [DW-1:0] d);
        int i = 0;
        int guard = 0;
        int dcnt = done_cnt;
        issue_start(MODE_WR, b, (AW+1)'(n));
        while (i < n && guard < 200) begin
            s_valid = 1'b1;
            s_data  = d + DW'(i);
            @(negedge clk);
            if (s_ready) begin
                exp_mem[(int'(b) + i) % MS] = d + DW'(i);
                i++;
            end
            step();
            guard++;
        end
        s_valid = 1'b0;
        s_data  = '0;
        check("wr_accepted", 64'(i), 64'(n));
        repeat (3) step();
        check("wr_done_once", 64'(done_cnt - dcnt), 64'd1);
    endtask

    task automatic do_read(input logic [AW-1:0] b, input int n, input bit poke);
        int guard = 0;
        int dcnt = done_cnt;
        for (int i = 0; i < n; i++) exp_q.push_back(exp_mem[(int'(b) + i) % MS]);
        issue_start(MODE_RD, b, (AW+1)'(n));
        while (exp_q.size() != 0 && guard < 400) begin
            if (poke && guard == 2) begin
                start = 1'b1; mode = MODE_WR; base = 11'h200; len = 12'd3;
            end else begin
                start = 1'b0;
            end
            step();
            guard++;
        end
        start = 1'b0;
        check("rd_remaining", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (3) step();
        check("rd_done_once", 64'(done_cnt - dcnt), 64'd1);
        check("rd_outst_le2", 64'(max_outst <= 2), 64'd1);
        if (rdy_mode == 0) check("rd_throughput_last", 64'(last_hs), 64'(3 + n - 1));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int dcnt;
        for (int i = 0; i < MS; i++) begin
            ram[i]     = 32'hDEAD_0000 | DW'(i);
            exp_mem[i] = 32'hDEAD_0000 | DW'(i);
        end
        rst = 1'b1; start = 1'b0; mode = 1'b0; base = '0; len = '0;
        s_valid = 1'b0; s_data = '0; q0 = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", 64'({busy, done, s_ready, m_valid, ce0, we0, addr0}), 64'd0);
        check("rst_mdata", 64'(m_data), 64'd0);
        check("rst_d0", 64'(d0), 64'd0);
        check("rst_state", 64'(fsm_state), 64'(ST_IDLE));
        step();
        rst = 1'b0;

        // Write 0xA0..0xA7 at 0x010 then read back at full rate.
        do_write(11'h010, 8, 32'hA0);
        for (int i = 0; i < 8; i++) check("wr_ram_a0", 64'(ram[16 + i]), 64'(32'hA0 + i));
        do_read(11'h010, 8, 1'b0);
        check("rd_first_valid_cyc", 64'(first_mv), 64'd3);

        // Wrap past the top of memory.
        do_write(11'h7FE, 4, 32'd1);
        check("wrap_7fe", 64'(ram[2046]), 64'd1);
        check("wrap_7ff", 64'(ram[2047]), 64'd2);
        check("wrap_000", 64'(ram[0]), 64'd3);
        check("wrap_001", 64'(ram[1]), 64'd4);
        do_read(11'h7FE, 4, 1'b0);

        // Backpressure on a 16-word read.
        rdy_mode = 1;
        do_read(11'h010, 16, 1'b0);
        rdy_mode = 0;

        // Zero-length command.
        dcnt = done_cnt;
        ce0_seen = 1'b0;
        done_cyc = -1;
        issue_start(MODE_WR, 11'h055, 12'd0);
        repeat (4) step();
        check("len0_done_cyc", 64'(done_cyc), 64'd2);
        check("len0_no_ce0", 64'(ce0_seen), 64'd0);
        check("len0_done_once", 64'(done_cnt - dcnt), 64'd1);

        // Reset after 5 of 10 writes.
        begin
            int i = 0;
            int guard = 0;
            issue_start(MODE_WR, 11'h100, 12'd10);
            while (i < 5 && guard < 50) begin
                s_valid = 1'b1;
                s_data  = 32'h77 + DW'(i);
                @(negedge clk);
                if (s_ready) i++;
                step();
                guard++;
            end
            check("midrst_accepted", 64'(i), 64'd5);
            dcnt = done_cnt;
            rst = 1'b1;
            step();
            rst = 1'b0;
            @(negedge clk);
            check("midrst_ctl", 64'({busy, done, s_ready, m_valid, ce0, we0, addr0}), 64'd0);
            check("midrst_mdata", 64'(m_data), 64'd0);
            check("midrst_d0", 64'(d0), 64'd0);
            check("midrst_state", 64'(fsm_state), 64'(ST_IDLE));
            s_valid = 1'b0;
            s_data  = '0;
            repeat (4) step();
            check("midrst_no_done", 64'(done_cnt - dcnt), 64'd0);
        end
        do_write(11'h300, 4, 32'h50);
        check("post_rst_ram", 64'(ram[11'h302]), 64'h52);
        do_read(11'h300, 4, 1'b0);

        // start pulsed during a read burst must be ignored.
        do_read(11'h010, 8, 1'b1);
        check("poke_ram_untouched", 64'(ram[11'h200]), 64'h0000_0000_DEAD_0200);
        check("poke_idle", 64'(fsm_state), 64'(ST_IDLE));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish by time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/omp_q_mem_ctrl.md
OMP_Q_MEM_CTRL -- requirements
Module: omp_q_mem_ctrl

Interface
REQ-001 Parameters SHALL be: DWIDTH, default 32, data width; AWIDTH, default 11, address width; MEM_SIZE, default 2048, words, always 2**AWIDTH.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 start  in  1  command request, sampled only in IDLE.
REQ-005 mode  in  1  0 = write burst, 1 = read burst.
REQ-006 base  in  AWIDTH  first word address.
REQ-007 len  in  AWIDTH+1  word count, 0..MEM_SIZE.
REQ-008 busy  out  1  high in WRITE/READ states.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 s_data  in  DWIDTH; s_valid  in  1; s_ready  out  1  write-data stream.
REQ-011 m_data  out  DWIDTH; m_valid  out  1; m_ready  in  1  read-data stream.
REQ-012 addr0  out  AWIDTH; ce0  out  1; we0  out  1; d0  out  DWIDTH; q0  in  DWIDTH  single-port RAM master. The RAM returns q0 one cycle after ce0 with we0=0.

Function
REQ-013 The FSM SHALL have states IDLE, WRITE, READ, DONE.
REQ-014 IDLE SHALL latch base/len/mode when start=1, then go to WRITE or READ per mode, or to DONE if len=0.
REQ-015 start outside IDLE SHALL be ignored.
REQ-016 The word address SHALL be (base + index) mod MEM_SIZE; wrap past MEM_SIZE-1 goes to 0.
REQ-017 In WRITE: s_ready=1; each cycle with s_valid=1 drives ce0=we0=1, d0=s_data, addr0=current address, and advances the index.
REQ-018 WRITE SHALL move to DONE in the cycle after the len-th accepted word.
REQ-019 In READ, a read (ce0=1, we0=0) SHALL be issued when buffer occupancy + in-flight reads < 2 and issued count < len.
REQ-020 q0 SHALL be captured into a 2-entry FIFO the cycle after issue. m_valid = FIFO non-empty; m_data = FIFO head.
REQ-021 Read latency: start high in cycle 0 gives first ce0 in cycle 1 and m_valid in cycle 3. With m_ready held at 1, throughput SHALL be one word per cycle.
REQ-022 m_data SHALL stay stable while m_valid=1 and m_ready=0. No word is lost or duplicated under any backpressure pattern.
REQ-023 READ SHALL move to DONE in the cycle after the len-th m_valid&m_ready handshake.
REQ-024 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-025 Outside WRITE/READ: ce0=0, we0=0, s_ready=0, m_valid=0.
REQ-026 In READ: we0=0 and d0=0.
REQ-027 len=MEM_SIZE SHALL touch every address exactly once.

Reset
REQ-028 rst SHALL force IDLE and flush the FIFO and in-flight count. All outputs go to 0: busy, done, s_ready, m_valid, m_data, addr0, ce0, we0, d0.
REQ-029 rst during WRITE/READ SHALL abort the burst with no done pulse. No ce0 is issued in the cycle after rst is sampled.

Structure
REQ-030 Shared package omp_q_pkg SHALL hold DWIDTH, AWIDTH, MEM_SIZE defaults, the state encoding, and the MODE_WR/MODE_RD constants.
REQ-031 The 2-entry read buffer SHALL be sub-module omp_q_rd_buf, with push/pop/occupancy and synchronous active-high reset.
REQ-032 The FSM, address counter and issue logic SHALL live in omp_q_mem_ctrl.

Verification
REQ-033 Bench SHALL use a behavioural single-port RAM model (1-cycle read, write-first q0).
REQ-034 Write then read: write 0xA0..0xA7 at base 0x010, len 8, s_valid always 1, then read same range with m_ready=1 -> reads return 0xA0..0xA7 in order; done pulses once per burst; read m_valid first in cycle 3.
REQ-035 Wrap: write base 0x7FE, len 4, data 1..4 -> RAM[0x7FE]=1, [0x7FF]=2, [0x000]=3, [0x001]=4; readback matches.
REQ-036 Backpressure: read len 16, m_ready toggling 1,0,0,1 plus random gaps -> exactly 16 words, in order, m_data stable while stalled, at most 2 reads outstanding.
REQ-037 len=0 -> done pulses in cycle 2 after start; ce0 never asserts.
REQ-038 Reset mid-burst: rst asserted after 5 of 10 writes -> next cycle ce0=0, all outputs 0, no done; a new command afterwards completes normally.
REQ-039 start pulsed while busy -> ignored; the burst completes with the original base/len.
